// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: checker state encoding,
// XNOR-LFSR tap masks and generator seed.
package prbs_checker_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    CHECK  = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  // Bit p-1 set means stage p is a feedback tap
  function automatic logic [15:0] tap_mask(input int n);
    logic [15:0] m;
    case (n)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Alternating pattern with stage 1 set
  function automatic logic [15:0] seed(input int n);
    logic [31:0] m;
    m = (32'h1 << n) - 32'h1;
    return 16'h5555 & m[15:0];
  endfunction

endpackage

// File: rtl/prbs_checker_tap_xnor.sv
// Combinational XNOR of the LFSR taps for the
// configured length: the next expected bit.
module prbs_tap_xnor
  import prbs_checker_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] state,
  output logic                fb
);

  localparam logic [15:0] MASK = tap_mask(NUM_BITS);

  logic [NUM_BITS-1:0] taps;

  assign taps = MASK[NUM_BITS-1:0];
  assign fb   = ~^(state & taps);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker with windowed
// loss-of-lock detection and saturating error count.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int WINDOW      = 32,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = $clog2(NUM_BITS + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [15:0] SEED_W = seed(NUM_BITS);
  localparam logic [NUM_BITS-1:0] SEED =
    SEED_W[NUM_BITS-1:0];

  state_t state, state_n;

  logic [NUM_BITS-1:0] s, s_n, s_sh;
  logic [FW-1:0]       fill, fill_n;
  logic [WW-1:0]       win, win_n;
  logic [EW-1:0]       werr, werr_n;
  logic                pulse_n;
  logic [CNT_W-1:0]    cnt_n;
  logic                exp_bit;
  logic                mismatch;

  prbs_tap_xnor #(
    .NUM_BITS(NUM_BITS)
  ) u_tap (
    .state(s),
    .fb   (exp_bit)
  );

  assign s_sh     = {s[NUM_BITS-2:0], bit_in};
  assign mismatch = bit_in ^ exp_bit;
  assign locked   = (state == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      s         <= SEED;
      fill      <= '0;
      win       <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      fill      <= fill_n;
      win       <= win_n;
      werr      <= werr_n;
      err_pulse <= pulse_n;
      err_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    fill_n  = fill;
    win_n   = win;
    werr_n  = werr;
    pulse_n = 1'b0;
    cnt_n   = err_count;
    if (bit_valid) begin
      s_n = s_sh;
      unique case (state)
        SEARCH: begin
          if (fill == FW'(NUM_BITS - 1)) begin
            fill_n = '0;
            // all-ones is the XNOR lock-up state
            if (!(&s_sh)) state_n = CHECK;
          end else begin
            fill_n = fill + 1'b1;
          end
        end
        CHECK: begin
          pulse_n = mismatch;
          if (mismatch &&
              werr == EW'(LOSS_THRESH - 1)) begin
            state_n = SEARCH;
            fill_n  = '0;
            win_n   = '0;
            werr_n  = '0;
          end else if (win == WW'(WINDOW - 1)) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win + 1'b1;
            werr_n = werr + EW'(mismatch);
          end
        end
      endcase
    end
    if (clr_cnt)
      cnt_n = '0;
    else if (pulse_n && err_count != 16'hFFFF)
      cnt_n = err_count + 16'd1;
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: random
// stimulus against a queue-based reference model.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  prbs_checker #(
    .NUM_BITS   (8),
    .WINDOW     (32),
    .LOSS_THRESH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  typedef struct packed {
    logic        l;
    logic        p;
    logic [15:0] c;
  } exp_t;

  exp_t  sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  string phase = "reset";

  // generator: bit p of the LFSR held at g[p-1]
  logic [7:0] g;

  // model: hist[k] is the bit received k+1 bits ago
  bit m_lock;
  int m_fill, m_win, m_werr, m_cnt;
  int hist[$];

  task automatic chk(string name, logic [15:0] act,
                     logic [15:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  name, act, want);
  endtask

  function automatic void model_reset();
    m_lock = 0;
    m_fill = 0;
    m_win  = 0;
    m_werr = 0;
    m_cnt  = 0;
    hist   = {};
    for (int i = 0; i < 8; i++)
      hist.push_back((i % 2 == 0) ? 1 : 0);
    g = 8'h55;
  endfunction

  function automatic void model_step(input bit b,
    input bit v, input bit c, output bit pulse);
    int e;
    bit ones;
    pulse = 0;
    if (v) begin
      if (!m_lock) begin
        hist.push_front(int'(b));
        while (hist.size() > 8) void'(hist.pop_back());
        m_fill++;
        if (m_fill == 8) begin
          m_fill = 0;
          ones = 1;
          foreach (hist[k]) if (hist[k] == 0) ones = 0;
          if (!ones) begin
            m_lock = 1;
            m_win  = 0;
            m_werr = 0;
          end
        end
      end else begin
        e = ((hist[7] + hist[5] + hist[4] + hist[3])
             % 2 == 0) ? 1 : 0;
        pulse = (int'(b) != e);
        hist.push_front(int'(b));
        while (hist.size() > 8) void'(hist.pop_back());
        m_win++;
        if (pulse) m_werr++;
        if (pulse && m_werr == 4) begin
          m_lock = 0;
          m_fill = 0;
          m_win  = 0;
          m_werr = 0;
        end else if (m_win == 32) begin
          m_win  = 0;
          m_werr = 0;
        end
      end
    end
    if (c) m_cnt = 0;
    else if (pulse && m_cnt < 65535) m_cnt++;
  endfunction

  task automatic step(bit b, bit v, bit c);
    bit   p;
    exp_t e;
    bit_in    = b;
    bit_valid = v;
    clr_cnt   = c;
    model_step(b, v, c, p);
    e.l = m_lock;
    e.p = p;
    e.c = 16'(m_cnt);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // flip corrupts the generator's own register too
  task automatic send(bit flip, bit v, bit c);
    bit nb;
    if (v) begin
      nb = ~(g[7] ^ g[5] ^ g[4] ^ g[3]) ^ flip;
      g  = {g[6:0], nb};
      step(nb, 1'b1, c);
    end else begin
      step(1'($urandom_range(1, 0)), 1'b0, c);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_pulse", 16'(err_pulse), 16'd0);
    chk("rst_count", err_count, 16'd0);
    rst_n = 1'b1;
  endtask

  task automatic fill8(string tag);
    for (int i = 0; i < 7; i++) send(1'b0, 1'b1, 1'b0);
    chk({tag, "_pre"}, 16'(locked), 16'd0);
    send(1'b0, 1'b1, 1'b0);
    chk({tag, "_lock"}, 16'(locked), 16'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if ({locked, err_pulse, err_count} === e)
          n_pass++;
        else
          $display(
            "FAIL %s: lock/pulse/cnt got %b/%b/%h want %b/%b/%h",
            phase, locked, err_pulse, err_count,
            e.l, e.p, e.c);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    bit f, v, c;
    @(negedge clk);
    do_reset();

    phase = "lock";
    fill8("lock");
    chk("lock_count", err_count, 16'd0);

    phase = "clean";
    repeat (1000)
      send(1'b0, 1'($urandom_range(1, 0)), 1'b0);
    chk("clean_locked", 16'(locked), 16'd1);
    chk("clean_count", err_count, 16'd0);

    phase = "flip1";
    send(1'b1, 1'b1, 1'b0);
    chk("flip1_pulse", 16'(err_pulse), 16'd1);
    chk("flip1_count", err_count, 16'd1);
    send(1'b0, 1'b1, 1'b0);
    chk("flip1_pulse_off", 16'(err_pulse), 16'd0);
    chk("flip1_locked", 16'(locked), 16'd1);

    do_reset();
    phase = "loss";
    fill8("loss");
    for (int i = 0; i < 11; i++)
      send((i % 3) == 1, 1'b1, 1'b0);
    chk("loss_locked", 16'(locked), 16'd0);
    chk("loss_count", err_count, 16'd4);
    phase = "relock";
    fill8("relock");

    phase = "sat";
    force dut.err_count = 16'hFFFE;
    m_cnt = 65534;
    send(1'b0, 1'b0, 1'b0);
    release dut.err_count;
    for (int i = 0; i < 9; i++)
      send((i % 3) == 0, 1'b1, 1'b0);
    chk("sat_count", err_count, 16'hFFFF);
    repeat (40) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    chk("clr_pulse", 16'(err_pulse), 16'd1);
    chk("clr_count", err_count, 16'd0);

    do_reset();
    phase = "ones";
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("ones_locked", 16'(locked), 16'd0);
    fill8("ones");

    phase = "rst_mid";
    repeat (5) send(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_locked", 16'(locked), 16'd0);
    @(negedge clk);
    do_reset();
    fill8("rst_mid");

    phase = "random";
    repeat (3000) begin
      f = ($urandom_range(99, 0) < 3);
      v = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(199, 0) == 0);
      send(f, v, c);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
